// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared definitions for the memory-access stage.
// Holds widths, the FSM state encoding, load size codes and a lane counter.
package mem_access_pkg;

    localparam int XLEN    = 64;
    localparam int REG_BUS = 5;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2,
        MEM_DONE = 2'd3
    } mem_state_e;

    localparam logic [3:0] SZ_B = 4'd1;
    localparam logic [3:0] SZ_H = 4'd2;
    localparam logic [3:0] SZ_W = 4'd4;
    localparam logic [3:0] SZ_D = 4'd8;

    // Number of enabled byte lanes; the access size in bytes.
    function automatic logic [3:0] be_count(input logic [7:0] be);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, be[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// load_align: shifts the captured bus word down to the addressed lane,
// decodes size from the lane mask and zero/sign-extends to XLEN.
// Ports: i_ld_buf, i_offset (addr[2:0]), i_byte_enable, i_ext_un -> o_data.
module load_align
    import mem_access_pkg::*;
(
    input  logic [XLEN-1:0] i_ld_buf,
    input  logic [2:0]      i_offset,
    input  logic [7:0]      i_byte_enable,
    input  logic            i_ext_un,
    output logic [XLEN-1:0] o_data
);

    logic [XLEN-1:0] w_sh;
    logic [3:0]      w_size;

    assign w_sh   = i_ld_buf >> {i_offset, 3'b000};
    assign w_size = be_count(i_byte_enable);

    always_comb begin
        o_data = '0;
        case (w_size)
            SZ_B: o_data = i_ext_un ? {{(XLEN-8){1'b0}}, w_sh[7:0]}
                                    : {{(XLEN-8){w_sh[7]}}, w_sh[7:0]};
            SZ_H: o_data = i_ext_un ? {{(XLEN-16){1'b0}}, w_sh[15:0]}
                                    : {{(XLEN-16){w_sh[15]}}, w_sh[15:0]};
            SZ_W: o_data = i_ext_un ? {{(XLEN-32){1'b0}}, w_sh[31:0]}
                                    : {{(XLEN-32){w_sh[31]}}, w_sh[31:0]};
            SZ_D: o_data = w_sh;
            // Non power-of-two lane masks are malformed; return zero.
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage; runs a req/gnt/rvalid data-bus transaction for
// loads/stores, stalls upstream until done, and drives the write-back triple.
// Ports: EX/ME inputs, dbus_* request/response, stall_req, wb_* to ME/WB.
module mem_access
    import mem_access_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               mem_rena,
    input  logic               mem_wena,
    input  logic               mem_ext_un,
    input  logic               mem_to_reg,
    input  logic [7:0]         byte_enable,
    input  logic [XLEN-1:0]    alu_result,
    input  logic [XLEN-1:0]    rs2_data,
    input  logic               rd_wena,
    input  logic [REG_BUS-1:0] rd_waddr,
    output logic               dbus_req,
    output logic               dbus_we,
    output logic [XLEN-1:0]    dbus_addr,
    output logic [XLEN-1:0]    dbus_wdata,
    output logic [7:0]         dbus_wstrb,
    input  logic               dbus_gnt,
    input  logic               dbus_rvalid,
    input  logic [XLEN-1:0]    dbus_rdata,
    output logic               stall_req,
    output logic               wb_valid,
    output logic               wb_rd_wena,
    output logic [REG_BUS-1:0] wb_rd_waddr,
    output logic [XLEN-1:0]    wb_rd_wdata
);

    mem_state_e      r_state;
    mem_state_e      w_next;
    logic [XLEN-1:0] r_ld_buf;
    logic            w_access;
    logic            w_is_load;
    logic            w_be_any;
    logic            w_stall;
    logic            w_req;
    logic [XLEN-1:0] w_aligned;

    assign w_be_any  = (byte_enable != 8'h00);
    assign w_access  = in_valid & (mem_rena | mem_wena) & w_be_any;
    // Load and store both set means store: no data comes back.
    assign w_is_load = mem_rena & ~mem_wena;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= MEM_IDLE;
            r_ld_buf <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == MEM_WAIT && dbus_rvalid && w_is_load) begin
                r_ld_buf <= dbus_rdata;
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        w_req   = 1'b0;
        case (r_state)
            MEM_IDLE: begin
                w_stall = w_access;
                if (w_access) begin
                    w_next = MEM_REQ;
                end
            end
            MEM_REQ: begin
                w_stall = 1'b1;
                w_req   = 1'b1;
                if (dbus_gnt) begin
                    w_next = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                w_stall = 1'b1;
                if (dbus_rvalid) begin
                    w_next = MEM_DONE;
                end
            end
            MEM_DONE: begin
                w_next = MEM_IDLE;
            end
            default: begin
                w_next = MEM_IDLE;
            end
        endcase
    end

    load_align u_load_align (
        .i_ld_buf      (r_ld_buf),
        .i_offset      (alu_result[2:0]),
        .i_byte_enable (byte_enable),
        .i_ext_un      (mem_ext_un),
        .o_data        (w_aligned)
    );

    assign dbus_req   = w_req & ~rst;
    assign dbus_we    = mem_wena;
    assign dbus_addr  = {alu_result[XLEN-1:3], 3'b000};
    assign dbus_wdata = rs2_data << {alu_result[2:0], 3'b000};
    assign dbus_wstrb = mem_wena ? byte_enable : 8'h00;

    assign stall_req   = w_stall & ~rst;
    assign wb_valid    = in_valid & ~stall_req & ~rst;
    assign wb_rd_wena  = rd_wena & wb_valid;
    assign wb_rd_waddr = rd_waddr;
    assign wb_rd_wdata = (mem_to_reg & w_is_load & w_be_any) ? w_aligned
                                                             : alu_result;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: scoreboard bench for mem_access; a bus responder grants
// after a programmed delay and returns read data the cycle after grant.
module tb_mem_access;
    import mem_access_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, mem_rena, mem_wena, mem_ext_un, mem_to_reg;
    logic [7:0]         byte_enable;
    logic [XLEN-1:0]    alu_result, rs2_data;
    logic               rd_wena;
    logic [REG_BUS-1:0] rd_waddr;
    logic               dbus_req, dbus_we;
    logic [XLEN-1:0]    dbus_addr, dbus_wdata;
    logic [7:0]         dbus_wstrb;
    logic               dbus_gnt, dbus_rvalid;
    logic [XLEN-1:0]    dbus_rdata;
    logic               stall_req, wb_valid, wb_rd_wena;
    logic [REG_BUS-1:0] wb_rd_waddr;
    logic [XLEN-1:0]    wb_rd_wdata;

    mem_access dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .mem_rena(mem_rena), .mem_wena(mem_wena),
        .mem_ext_un(mem_ext_un), .mem_to_reg(mem_to_reg),
        .byte_enable(byte_enable), .alu_result(alu_result),
        .rs2_data(rs2_data), .rd_wena(rd_wena), .rd_waddr(rd_waddr),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
        .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
        .dbus_rdata(dbus_rdata), .stall_req(stall_req),
        .wb_valid(wb_valid), .wb_rd_wena(wb_rd_wena),
        .wb_rd_waddr(wb_rd_waddr), .wb_rd_wdata(wb_rd_wdata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_hs  = 0;
    int first_req_cyc = 0;
    int last_done_cyc = 0;
    logic [63:0] sb_data[$];
    logic [4:0]  sb_addr[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dbus_req && dbus_gnt) n_hs <= n_hs + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_load(input logic [63:0] rd,
                                             input logic [2:0] off,
                                             input logic [7:0] be,
                                             input logic un);
        logic [63:0] v, m;
        int n;
        n = $countones(be);
        if (!(n == 1 || n == 2 || n == 4 || n == 8)) return 64'd0;
        v = rd >> (off * 8);
        m = (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
        v = v & m;
        if (!un && v[8*n-1]) v = v | ~m;
        return v;
    endfunction

    task automatic op(input logic rd, input logic wr, input logic un,
                      input logic m2r, input logic [7:0] be,
                      input logic [63:0] addr, input logic [63:0] wdat,
                      input logic [4:0] rda, input logic rdw,
                      input int gdly, input logic [63:0] rdata);
        logic [63:0] expd;
        logic [63:0] ew;
        logic        acc;
        int          stalls, reqc, ph;
        bit          done;
        @(posedge clk); #1;
        in_valid = 1'b1; mem_rena = rd; mem_wena = wr; mem_ext_un = un;
        mem_to_reg = m2r; byte_enable = be; alu_result = addr;
        rs2_data = wdat; rd_wena = rdw; rd_waddr = rda;
        acc  = (rd | wr) & (be != 8'h00);
        expd = (m2r && rd && !wr && be != 8'h00)
               ? exp_load(rdata, addr[2:0], be, un) : addr;
        ew   = wdat << (addr[2:0] * 8);
        if (rdw) begin
            sb_data.push_back(expd);
            sb_addr.push_back(rda);
        end
        stalls = 0; reqc = 0; ph = 0; done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
            if (ph == 1) begin
                dbus_rvalid = 1'b1; dbus_rdata = rdata; ph = 2;
            end
            #1;
            if (dbus_req) begin
                if (reqc == 0) first_req_cyc = cyc;
                chk("req_addr", dbus_addr, {addr[63:3], 3'b000});
                chk("req_wdata", dbus_wdata, ew);
                chk("req_wstrb", {56'd0, dbus_wstrb}, wr ? {56'd0, be} : 64'd0);
                chk("req_we", {63'd0, dbus_we}, {63'd0, wr});
                reqc++;
                if (reqc > gdly) begin dbus_gnt = 1'b1; ph = 1; end
            end
            if (stall_req) stalls++;
            if (wb_valid) begin done = 1; last_done_cyc = cyc; end
        end
        chk("op_done", {63'd0, done}, 64'd1);
        chk("stall_cycles", stalls, acc ? (3 + gdly) : 0);
        chk("req_cycles", reqc, acc ? (gdly + 1) : 0);
        if (done && wb_rd_wena) begin
            if (sb_data.size() == 0) begin
                chk("sb_empty", 64'd1, 64'd0);
            end else begin
                chk("wb_addr", {59'd0, wb_rd_waddr}, {59'd0, sb_addr.pop_front()});
                chk("wb_data", wb_rd_wdata, sb_data.pop_front());
            end
        end else if (done) begin
            chk("wb_wena", {63'd0, wb_rd_wena}, {63'd0, rdw});
            chk("wb_data_nw", wb_rd_wdata, expd);
        end
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
    endtask

    task automatic bubble_in;
        in_valid = 1'b0; mem_rena = 1'b0; mem_wena = 1'b0;
        mem_ext_un = 1'b0; mem_to_reg = 1'b0; byte_enable = 8'h00;
        alu_result = '0; rs2_data = '0; rd_wena = 1'b0; rd_waddr = '0;
    endtask

    initial begin
        int hs0, d0;
        rst = 1'b1;
        bubble_in();
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;
        @(posedge clk); #1;
        // Enables must stay low while reset is asserted, even with a load.
        in_valid = 1'b1; mem_rena = 1'b1; byte_enable = 8'hFF; rd_wena = 1'b1;
        #1;
        chk("rst_stall", {63'd0, stall_req}, 64'd0);
        chk("rst_wbv", {63'd0, wb_valid}, 64'd0);
        chk("rst_wbw", {63'd0, wb_rd_wena}, 64'd0);
        chk("rst_req", {63'd0, dbus_req}, 64'd0);
        bubble_in();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_ldbuf", dut.r_ld_buf, 64'd0);

        // ALU pass-through
        op(0, 0, 0, 0, 8'h00, 64'h1234, 64'd0, 5, 1, 0, 64'd0);
        // signed / unsigned byte load
        op(1, 0, 0, 1, 8'h08, 64'h1003, 64'd0, 7, 1, 0, 64'h0000_0000_8000_0000);
        op(1, 0, 1, 1, 8'h08, 64'h1003, 64'd0, 8, 1, 0, 64'h0000_0000_8000_0000);
        // store word, grant delayed
        op(0, 1, 0, 0, 8'hF0, 64'h2004, 64'hDEADBEEF, 0, 0, 4, 64'd0);
        // halfword, word, double, malformed mask
        op(1, 0, 0, 1, 8'hC0, 64'h3006, 64'd0, 9, 1, 1, 64'h7FFE_1111_2222_3333);
        op(1, 0, 0, 1, 8'hF0, 64'h3004, 64'd0, 10, 1, 2, 64'h8000_0001_1234_5678);
        op(1, 0, 1, 1, 8'hF0, 64'h3004, 64'd0, 11, 1, 0, 64'h8000_0001_1234_5678);
        op(1, 0, 0, 1, 8'hFF, 64'h3000, 64'd0, 12, 1, 0, 64'hF0E1_D2C3_B4A5_9687);
        op(1, 0, 0, 1, 8'h07, 64'h3000, 64'd0, 13, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        // zero lane mask is a no-op; load+store is a store
        op(1, 0, 0, 1, 8'h00, 64'h4444, 64'd0, 14, 1, 0, 64'd0);
        op(1, 1, 0, 1, 8'h0F, 64'h5000, 64'h55AA, 15, 1, 0, 64'hFFFF_0000);

        // bubble with stale load controls
        @(posedge clk); #1;
        bubble_in();
        mem_rena = 1'b1; byte_enable = 8'hFF; rd_wena = 1'b1;
        #1;
        chk("bub_wbv", {63'd0, wb_valid}, 64'd0);
        chk("bub_stall", {63'd0, stall_req}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            chk("bub_req", {63'd0, dbus_req}, 64'd0);
        end

        // reset while in WAIT
        @(posedge clk); #1;
        in_valid = 1'b1; mem_rena = 1'b1; mem_to_reg = 1'b1;
        byte_enable = 8'hFF; alu_result = 64'h6000; rd_wena = 1'b1;
        @(posedge clk); #1;
        dbus_gnt = 1'b1;
        @(posedge clk); #1;
        dbus_gnt = 1'b0;
        rst = 1'b1; bubble_in();
        #1;
        chk("rw_stall", {63'd0, stall_req}, 64'd0);
        chk("rw_wbv", {63'd0, wb_valid}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        dbus_rvalid = 1'b1; dbus_rdata = 64'hAA;
        #1;
        chk("rw_state", {62'd0, dut.r_state}, {62'd0, MEM_IDLE});
        chk("rw_req", {63'd0, dbus_req}, 64'd0);
        chk("rw_stall2", {63'd0, stall_req}, 64'd0);
        @(posedge clk); #1;
        dbus_rvalid = 1'b0;
        chk("rw_ldbuf", dut.r_ld_buf, 64'd0);

        // back-to-back loads
        hs0 = n_hs;
        op(1, 0, 1, 1, 8'hFF, 64'h0, 64'd0, 20, 1, 0, 64'h0123_4567_89AB_CDEF);
        d0 = last_done_cyc;
        op(1, 0, 1, 1, 8'hFF, 64'h8, 64'd0, 21, 1, 0, 64'hFEDC_BA98_7654_3210);
        chk("b2b_gap", first_req_cyc - d0 - 1, 64'd1);
        @(posedge clk); #1;
        bubble_in();
        #1;
        chk("b2b_hs", n_hs - hs0, 64'd2);
        chk("sb_left", sb_data.size(), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
